// File: rtl/axi4_mmio_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_mmio_arb_pkg
// Purpose  : Shared types and constants for the 2:1 AXI4 MMIO arbiter.
//            Write/read FSM state encodings and AXI response codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axi4_mmio_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage : axi4_mmio_arb_pkg
`default_nettype wire

// File: rtl/mmio_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mmio_rr_pick
// Purpose  : Two-way request picker. A lone requester always wins; when both
//            request, the pointer chooses. On advance the pointer moves to
//            the master that did not win, so the loser is favoured next time.
// Ports    : req[1:0] in  - request vector (bit N = master N)
//            ptr      in  - current preferred master
//            advance  in  - a grant is being taken this cycle
//            grant    out - index of the winning master
//            ptr_next out - pointer value for the next cycle
// Revision : 1.0 - initial release
// ============================================================================
module mmio_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  output logic       grant,
  output logic       ptr_next
);

  // With a single request the answer is simply whether master 1 asked.
  assign grant    = (&req) ? ptr : req[1];
  assign ptr_next = advance ? ~grant : ptr;

endmodule : mmio_rr_pick
`default_nettype wire

// File: rtl/axi4_mmio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_mmio_arbiter
// Purpose  : 2:1 AXI4 arbiter sharing one MMIO slave port between master 0
//            (core) and master 1 (debug/DMA). Independent write and read
//            arbiters, one outstanding transaction per direction; the grant
//            is held from the address handshake to the final response.
// Config   : MMIO_ARB_FIXED_PRIO_EN - when defined master 0 wins simultaneous
//            requests and the round-robin pointers are not built.
// Ports    : clock, resetn         - clock, async active-low reset
//            s0_axi_*, s1_axi_*    - upstream AXI4 slave ports (from masters)
//            m_axi_*               - downstream AXI4 master port
//            wr_owner, rd_owner    - current grants (meaningful when busy)
// Revision : 1.0 - initial release
// ============================================================================
module axi4_mmio_arbiter
  import axi4_mmio_arb_pkg::*;
#(
  parameter int ADDR_W = 31,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                resetn,
  // master 0
  input  logic                s0_axi_awvalid,
  input  logic [ID_W-1:0]     s0_axi_awid,
  input  logic [ADDR_W-1:0]   s0_axi_awaddr,
  input  logic [7:0]          s0_axi_awlen,
  input  logic [2:0]          s0_axi_awsize,
  input  logic [1:0]          s0_axi_awburst,
  output logic                s0_axi_awready,
  input  logic                s0_axi_wvalid,
  input  logic [DATA_W-1:0]   s0_axi_wdata,
  input  logic [DATA_W/8-1:0] s0_axi_wstrb,
  input  logic                s0_axi_wlast,
  output logic                s0_axi_wready,
  output logic                s0_axi_bvalid,
  output logic [ID_W-1:0]     s0_axi_bid,
  output logic [1:0]          s0_axi_bresp,
  input  logic                s0_axi_bready,
  input  logic                s0_axi_arvalid,
  input  logic [ID_W-1:0]     s0_axi_arid,
  input  logic [ADDR_W-1:0]   s0_axi_araddr,
  input  logic [7:0]          s0_axi_arlen,
  input  logic [2:0]          s0_axi_arsize,
  input  logic [1:0]          s0_axi_arburst,
  output logic                s0_axi_arready,
  output logic                s0_axi_rvalid,
  output logic [ID_W-1:0]     s0_axi_rid,
  output logic [DATA_W-1:0]   s0_axi_rdata,
  output logic [1:0]          s0_axi_rresp,
  output logic                s0_axi_rlast,
  input  logic                s0_axi_rready,
  // master 1
  input  logic                s1_axi_awvalid,
  input  logic [ID_W-1:0]     s1_axi_awid,
  input  logic [ADDR_W-1:0]   s1_axi_awaddr,
  input  logic [7:0]          s1_axi_awlen,
  input  logic [2:0]          s1_axi_awsize,
  input  logic [1:0]          s1_axi_awburst,
  output logic                s1_axi_awready,
  input  logic                s1_axi_wvalid,
  input  logic [DATA_W-1:0]   s1_axi_wdata,
  input  logic [DATA_W/8-1:0] s1_axi_wstrb,
  input  logic                s1_axi_wlast,
  output logic                s1_axi_wready,
  output logic                s1_axi_bvalid,
  output logic [ID_W-1:0]     s1_axi_bid,
  output logic [1:0]          s1_axi_bresp,
  input  logic                s1_axi_bready,
  input  logic                s1_axi_arvalid,
  input  logic [ID_W-1:0]     s1_axi_arid,
  input  logic [ADDR_W-1:0]   s1_axi_araddr,
  input  logic [7:0]          s1_axi_arlen,
  input  logic [2:0]          s1_axi_arsize,
  input  logic [1:0]          s1_axi_arburst,
  output logic                s1_axi_arready,
  output logic                s1_axi_rvalid,
  output logic [ID_W-1:0]     s1_axi_rid,
  output logic [DATA_W-1:0]   s1_axi_rdata,
  output logic [1:0]          s1_axi_rresp,
  output logic                s1_axi_rlast,
  input  logic                s1_axi_rready,
  // downstream
  output logic                m_axi_awvalid,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  input  logic                m_axi_awready,
  output logic                m_axi_wvalid,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  input  logic                m_axi_wready,
  input  logic                m_axi_bvalid,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  output logic                m_axi_bready,
  output logic                m_axi_arvalid,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  input  logic                m_axi_arready,
  input  logic                m_axi_rvalid,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  output logic                m_axi_rready,
  // debug
  output logic                wr_owner,
  output logic                rd_owner
);

  wr_state_e r_wr_state;
  rd_state_e r_rd_state;
  logic      r_wr_owner;
  logic      r_rd_owner;

  logic [1:0] w_aw_req;
  logic [1:0] w_ar_req;
  logic       w_wr_take;
  logic       w_rd_take;
  logic       w_wr_grant;
  logic       w_rd_grant;
  logic       w_wr_ptr;
  logic       w_rd_ptr;
  logic       w_wr_ptr_nxt;
  logic       w_rd_ptr_nxt;

  assign w_aw_req  = {s1_axi_awvalid, s0_axi_awvalid};
  assign w_ar_req  = {s1_axi_arvalid, s0_axi_arvalid};
  assign w_wr_take = (r_wr_state == W_IDLE) && (|w_aw_req);
  assign w_rd_take = (r_rd_state == R_IDLE) && (|w_ar_req);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef MMIO_ARB_FIXED_PRIO_EN
  // Pointer pinned to master 0: it wins every tie.
  assign w_wr_ptr = 1'b0;
  assign w_rd_ptr = 1'b0;
`else
  logic r_wr_ptr;
  logic r_rd_ptr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  assign w_wr_ptr = r_wr_ptr;
  assign w_rd_ptr = r_rd_ptr;
`endif

  mmio_rr_pick u_wr_pick (
    .req      (w_aw_req),
    .ptr      (w_wr_ptr),
    .advance  (w_wr_take),
    .grant    (w_wr_grant),
    .ptr_next (w_wr_ptr_nxt)
  );

  mmio_rr_pick u_rd_pick (
    .req      (w_ar_req),
    .ptr      (w_rd_ptr),
    .advance  (w_rd_take),
    .grant    (w_rd_grant),
    .ptr_next (w_rd_ptr_nxt)
  );

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_state <= W_IDLE;
      r_wr_owner <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: if (w_wr_take) begin
          r_wr_owner <= w_wr_grant;
          r_wr_state <= W_ADDR;
        end
        W_ADDR: if (m_axi_awvalid && m_axi_awready) r_wr_state <= W_DATA;
        W_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) r_wr_state <= W_RESP;
        W_RESP: if (m_axi_bvalid && m_axi_bready) r_wr_state <= W_IDLE;
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rd_state <= R_IDLE;
      r_rd_owner <= 1'b0;
    end else begin
      case (r_rd_state)
        R_IDLE: if (w_rd_take) begin
          r_rd_owner <= w_rd_grant;
          r_rd_state <= R_ADDR;
        end
        R_ADDR: if (m_axi_arvalid && m_axi_arready) r_rd_state <= R_DATA;
        R_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) r_rd_state <= R_IDLE;
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign wr_owner = r_wr_owner;
  assign rd_owner = r_rd_owner;

  // --------------------------------------------------------------------------
  // Write channel steering. Handshake signals are gated by state so the
  // non-owner (and an early W from the owner) sees nothing until its phase.
  // --------------------------------------------------------------------------
  logic w_wr_addr_ph;
  logic w_wr_data_ph;
  logic w_wr_resp_ph;

  assign w_wr_addr_ph = (r_wr_state == W_ADDR);
  assign w_wr_data_ph = (r_wr_state == W_DATA);
  assign w_wr_resp_ph = (r_wr_state == W_RESP);

  assign m_axi_awvalid  = w_wr_addr_ph & (r_wr_owner ? s1_axi_awvalid : s0_axi_awvalid);
  assign m_axi_awid     = r_wr_owner ? s1_axi_awid    : s0_axi_awid;
  assign m_axi_awaddr   = r_wr_owner ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m_axi_awlen    = r_wr_owner ? s1_axi_awlen   : s0_axi_awlen;
  assign m_axi_awsize   = r_wr_owner ? s1_axi_awsize  : s0_axi_awsize;
  assign m_axi_awburst  = r_wr_owner ? s1_axi_awburst : s0_axi_awburst;
  assign s0_axi_awready = w_wr_addr_ph & ~r_wr_owner & m_axi_awready;
  assign s1_axi_awready = w_wr_addr_ph &  r_wr_owner & m_axi_awready;

  assign m_axi_wvalid  = w_wr_data_ph & (r_wr_owner ? s1_axi_wvalid : s0_axi_wvalid);
  assign m_axi_wdata   = r_wr_owner ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb   = r_wr_owner ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast   = r_wr_owner ? s1_axi_wlast : s0_axi_wlast;
  assign s0_axi_wready = w_wr_data_ph & ~r_wr_owner & m_axi_wready;
  assign s1_axi_wready = w_wr_data_ph &  r_wr_owner & m_axi_wready;

  assign m_axi_bready  = w_wr_resp_ph & (r_wr_owner ? s1_axi_bready : s0_axi_bready);
  assign s0_axi_bvalid = w_wr_resp_ph & ~r_wr_owner & m_axi_bvalid;
  assign s1_axi_bvalid = w_wr_resp_ph &  r_wr_owner & m_axi_bvalid;
  assign s0_axi_bid    = m_axi_bid;
  assign s1_axi_bid    = m_axi_bid;
  assign s0_axi_bresp  = m_axi_bresp;
  assign s1_axi_bresp  = m_axi_bresp;

  // --------------------------------------------------------------------------
  // Read channel steering
  // --------------------------------------------------------------------------
  logic w_rd_addr_ph;
  logic w_rd_data_ph;

  assign w_rd_addr_ph = (r_rd_state == R_ADDR);
  assign w_rd_data_ph = (r_rd_state == R_DATA);

  assign m_axi_arvalid  = w_rd_addr_ph & (r_rd_owner ? s1_axi_arvalid : s0_axi_arvalid);
  assign m_axi_arid     = r_rd_owner ? s1_axi_arid    : s0_axi_arid;
  assign m_axi_araddr   = r_rd_owner ? s1_axi_araddr  : s0_axi_araddr;
  assign m_axi_arlen    = r_rd_owner ? s1_axi_arlen   : s0_axi_arlen;
  assign m_axi_arsize   = r_rd_owner ? s1_axi_arsize  : s0_axi_arsize;
  assign m_axi_arburst  = r_rd_owner ? s1_axi_arburst : s0_axi_arburst;
  assign s0_axi_arready = w_rd_addr_ph & ~r_rd_owner & m_axi_arready;
  assign s1_axi_arready = w_rd_addr_ph &  r_rd_owner & m_axi_arready;

  assign m_axi_rready  = w_rd_data_ph & (r_rd_owner ? s1_axi_rready : s0_axi_rready);
  assign s0_axi_rvalid = w_rd_data_ph & ~r_rd_owner & m_axi_rvalid;
  assign s1_axi_rvalid = w_rd_data_ph &  r_rd_owner & m_axi_rvalid;
  assign s0_axi_rid    = m_axi_rid;
  assign s1_axi_rid    = m_axi_rid;
  assign s0_axi_rdata  = m_axi_rdata;
  assign s1_axi_rdata  = m_axi_rdata;
  assign s0_axi_rresp  = m_axi_rresp;
  assign s1_axi_rresp  = m_axi_rresp;
  assign s0_axi_rlast  = m_axi_rlast;
  assign s1_axi_rlast  = m_axi_rlast;

`ifndef SYNTHESIS
  // The granted master must hold its address valid until accepted.
  a_aw_held : assert property (@(posedge clock) disable iff (!resetn)
    (r_wr_state == W_ADDR) |-> (r_wr_owner ? s1_axi_awvalid : s0_axi_awvalid));
  a_ar_held : assert property (@(posedge clock) disable iff (!resetn)
    (r_rd_state == R_ADDR) |-> (r_rd_owner ? s1_axi_arvalid : s0_axi_arvalid));
`endif

endmodule : axi4_mmio_arbiter
`default_nettype wire

// File: tb/tb_axi4_mmio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_mmio_arbiter
// Purpose  : Self-checking bench for axi4_mmio_arbiter. The bench plays both
//            upstream masters and the downstream slave.
// Config   : honours MMIO_ARB_FIXED_PRIO_EN for expected grant order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_mmio_arbiter;
  import axi4_mmio_arb_pkg::*;

  localparam int ADDR_W = 31;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int STRB_W = DATA_W / 8;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  // upstream, index = master number
  logic              awvalid [2];
  logic [ID_W-1:0]   awid    [2];
  logic [ADDR_W-1:0] awaddr  [2];
  logic [7:0]        awlen   [2];
  logic [2:0]        awsize  [2];
  logic [1:0]        awburst [2];
  logic              awready [2];
  logic              wvalid  [2];
  logic [DATA_W-1:0] wdata   [2];
  logic [STRB_W-1:0] wstrb   [2];
  logic              wlast   [2];
  logic              wready  [2];
  logic              bvalid  [2];
  logic [ID_W-1:0]   bid     [2];
  logic [1:0]        bresp   [2];
  logic              bready  [2];
  logic              arvalid [2];
  logic [ID_W-1:0]   arid    [2];
  logic [ADDR_W-1:0] araddr  [2];
  logic [7:0]        arlen   [2];
  logic [2:0]        arsize  [2];
  logic [1:0]        arburst [2];
  logic              arready [2];
  logic              rvalid  [2];
  logic [ID_W-1:0]   rid     [2];
  logic [DATA_W-1:0] rdata   [2];
  logic [1:0]        rresp   [2];
  logic              rlast   [2];
  logic              rready  [2];

  logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [ID_W-1:0]   m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]        m_axi_awlen, m_axi_arlen;
  logic [2:0]        m_axi_awsize, m_axi_arsize;
  logic [1:0]        m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
  logic [STRB_W-1:0] m_axi_wstrb;
  logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic              m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic              wr_owner, rd_owner;

  axi4_mmio_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock(clock), .resetn(resetn),
    .s0_axi_awvalid(awvalid[0]), .s0_axi_awid(awid[0]), .s0_axi_awaddr(awaddr[0]),
    .s0_axi_awlen(awlen[0]), .s0_axi_awsize(awsize[0]), .s0_axi_awburst(awburst[0]),
    .s0_axi_awready(awready[0]), .s0_axi_wvalid(wvalid[0]), .s0_axi_wdata(wdata[0]),
    .s0_axi_wstrb(wstrb[0]), .s0_axi_wlast(wlast[0]), .s0_axi_wready(wready[0]),
    .s0_axi_bvalid(bvalid[0]), .s0_axi_bid(bid[0]), .s0_axi_bresp(bresp[0]),
    .s0_axi_bready(bready[0]), .s0_axi_arvalid(arvalid[0]), .s0_axi_arid(arid[0]),
    .s0_axi_araddr(araddr[0]), .s0_axi_arlen(arlen[0]), .s0_axi_arsize(arsize[0]),
    .s0_axi_arburst(arburst[0]), .s0_axi_arready(arready[0]), .s0_axi_rvalid(rvalid[0]),
    .s0_axi_rid(rid[0]), .s0_axi_rdata(rdata[0]), .s0_axi_rresp(rresp[0]),
    .s0_axi_rlast(rlast[0]), .s0_axi_rready(rready[0]),
    .s1_axi_awvalid(awvalid[1]), .s1_axi_awid(awid[1]), .s1_axi_awaddr(awaddr[1]),
    .s1_axi_awlen(awlen[1]), .s1_axi_awsize(awsize[1]), .s1_axi_awburst(awburst[1]),
    .s1_axi_awready(awready[1]), .s1_axi_wvalid(wvalid[1]), .s1_axi_wdata(wdata[1]),
    .s1_axi_wstrb(wstrb[1]), .s1_axi_wlast(wlast[1]), .s1_axi_wready(wready[1]),
    .s1_axi_bvalid(bvalid[1]), .s1_axi_bid(bid[1]), .s1_axi_bresp(bresp[1]),
    .s1_axi_bready(bready[1]), .s1_axi_arvalid(arvalid[1]), .s1_axi_arid(arid[1]),
    .s1_axi_araddr(araddr[1]), .s1_axi_arlen(arlen[1]), .s1_axi_arsize(arsize[1]),
    .s1_axi_arburst(arburst[1]), .s1_axi_arready(arready[1]), .s1_axi_rvalid(rvalid[1]),
    .s1_axi_rid(rid[1]), .s1_axi_rdata(rdata[1]), .s1_axi_rresp(rresp[1]),
    .s1_axi_rlast(rlast[1]), .s1_axi_rready(rready[1]),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awready(m_axi_awready), .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bready(m_axi_bready), .m_axi_arvalid(m_axi_arvalid), .m_axi_arid(m_axi_arid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
    .wr_owner(wr_owner), .rd_owner(rd_owner)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] pat(input logic m, input int b);
    return {(m ? 32'hB1B1_0000 : 32'hA0A0_0000), 32'(b)} ^ 64'h1234_5678_9ABC_DEF0;
  endfunction
  function automatic logic [ADDR_W-1:0] base(input logic m);
    return m ? 31'h6001_0000 : 31'h6000_0000;
  endfunction
  function automatic logic [ID_W-1:0] idof(input logic m);
    return m ? 4'h9 : 4'h3;
  endfunction

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      awvalid[m] = 0; awid[m] = '0; awaddr[m] = '0; awlen[m] = '0; awsize[m] = 3'd3;
      awburst[m] = 2'b01; wvalid[m] = 0; wdata[m] = '0; wstrb[m] = '1; wlast[m] = 0;
      bready[m] = 0; arvalid[m] = 0; arid[m] = '0; araddr[m] = '0; arlen[m] = '0;
      arsize[m] = 3'd3; arburst[m] = 2'b01; rready[m] = 0;
    end
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bid = '0; m_axi_bresp = OKAY;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rid = '0; m_axi_rdata = '0;
    m_axi_rresp = OKAY; m_axi_rlast = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    tick(); tick();
    resetn = 1;
  endtask

  // One write by the expected winner 'own'; the loser's request is left as given.
  task automatic wr_txn(input logic [1:0] req, input int nbeats, input logic own,
                        input bit tog, input int bdly);
    logic l;
    int   beat, cyc;
    l = ~own;
    for (int m = 0; m < 2; m++) begin
      awvalid[m] = req[m]; awaddr[m] = base(m[0]); awid[m] = idof(m[0]);
      awlen[m] = 8'(nbeats - 1); wvalid[m] = req[m]; wdata[m] = pat(m[0], 0);
      wlast[m] = (nbeats == 1); bready[m] = 0;
    end
    m_axi_awready = 1; m_axi_wready = 1; m_axi_bvalid = 0;
    #1;
    chk("wr_bubble_awvalid", m_axi_awvalid, 0);
    tick();
    chk("wr_owner", wr_owner, own);
    chk("wr_m_awvalid", m_axi_awvalid, 1);
    chk("wr_m_awaddr", m_axi_awaddr, base(own));
    chk("wr_m_awid", m_axi_awid, idof(own));
    chk("wr_awready_win", awready[own], 1);
    chk("wr_awready_lose", awready[l], 0);
    chk("wr_early_w_held", {wready[own], m_axi_wvalid}, 0);
    tick();
    awvalid[own] = 0;
    beat = 0; cyc = 0;
    while (beat < nbeats && cyc < 40) begin
      wdata[own] = pat(own, beat); wlast[own] = (beat == nbeats - 1);
      m_axi_wready = tog ? cyc[0] : 1'b1;
      #1;
      chk("wr_m_wvalid", m_axi_wvalid, 1);
      chk("wr_m_wdata", m_axi_wdata, pat(own, beat));
      chk("wr_wready_win", wready[own], m_axi_wready);
      chk("wr_wready_lose", wready[l], 0);
      if (m_axi_wready) beat++;
      cyc++;
      tick();
    end
    chk("wr_beats", beat, nbeats);
    bready[own] = 0; bready[l] = 1;
    m_axi_bvalid = 1; m_axi_bid = idof(own); m_axi_bresp = OKAY;
    for (int i = 0; i < bdly; i++) begin
      #1;
      chk("wr_bp_m_bready", m_axi_bready, 0);
      chk("wr_bp_bvalid", bvalid[own], 1);
      tick();
    end
    bready[own] = 1;
    #1;
    chk("wr_w_closed", {m_axi_wvalid, wready[own]}, 0);
    chk("wr_bvalid_win", bvalid[own], 1);
    chk("wr_bid_win", bid[own], idof(own));
    chk("wr_bvalid_lose", bvalid[l], 0);
    chk("wr_m_bready", m_axi_bready, 1);
    tick();
    m_axi_bvalid = 0; bready[0] = 0; bready[1] = 0; wvalid[own] = 0;
    #1;
    chk("wr_done_idle", {m_axi_bready, bvalid[own], m_axi_wvalid}, 0);
  endtask

  task automatic rd_txn(input logic [1:0] req, input int nbeats, input logic own, input int rdly);
    logic l;
    l = ~own;
    for (int m = 0; m < 2; m++) begin
      arvalid[m] = req[m]; araddr[m] = base(m[0]) + 31'h40; arid[m] = idof(m[0]);
      arlen[m] = 8'(nbeats - 1);
    end
    m_axi_arready = 1; m_axi_rvalid = 0;
    #1;
    chk("rd_bubble_arvalid", m_axi_arvalid, 0);
    tick();
    chk("rd_owner", rd_owner, own);
    chk("rd_m_arvalid", m_axi_arvalid, 1);
    chk("rd_m_araddr", m_axi_araddr, base(own) + 31'h40);
    chk("rd_arready_win", arready[own], 1);
    chk("rd_arready_lose", arready[l], 0);
    tick();
    arvalid[own] = 0;
    rready[l] = 1;
    for (int b = 0; b < nbeats; b++) begin
      m_axi_rvalid = 1; m_axi_rdata = pat(own, b); m_axi_rid = idof(own);
      m_axi_rlast = (b == nbeats - 1); m_axi_rresp = OKAY;
      if (b == 0) begin
        for (int i = 0; i < rdly; i++) begin
          rready[own] = 0;
          #1;
          chk("rd_bp_m_rready", m_axi_rready, 0);
          chk("rd_bp_rdata", {rvalid[own], rdata[own]}, {1'b1, pat(own, 0)});
          tick();
        end
      end
      rready[own] = 1;
      #1;
      chk("rd_rvalid_win", rvalid[own], 1);
      chk("rd_rvalid_lose", rvalid[l], 0);
      chk("rd_rdata", rdata[own], pat(own, b));
      chk("rd_rlast", rlast[own], (b == nbeats - 1));
      chk("rd_m_rready", m_axi_rready, 1);
      tick();
    end
    #1;
    chk("rd_closed", {m_axi_rready, rvalid[own]}, 0);
    m_axi_rvalid = 0; m_axi_rlast = 0; rready[0] = 0; rready[1] = 0;
  endtask

  typedef struct {
    logic [1:0] req;
    int         nbeats;
    logic       exp_rr;
    logic       exp_fixed;
  } arb_vec_t;

  arb_vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b11, 1, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 2, 1'b1, 1'b0};
    vecs[2] = '{2'b11, 1, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 3, 1'b1, 1'b0};
    vecs[4] = '{2'b10, 1, 1'b1, 1'b1};
    vecs[5] = '{2'b11, 2, 1'b0, 1'b0};
    vecs[6] = '{2'b01, 1, 1'b0, 1'b0};
    vecs[7] = '{2'b11, 1, 1'b1, 1'b0};

    // Reset state, with requests already pending
    clear_inputs();
    resetn = 0;
    awvalid[0] = 1; arvalid[1] = 1; m_axi_awready = 1; m_axi_arready = 1;
    m_axi_bvalid = 1; m_axi_rvalid = 1;
    tick(); tick();
    chk("reset_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
        m_axi_rready, awready[0], awready[1], wready[0], wready[1], bvalid[0], bvalid[1],
        arready[0], arready[1], rvalid[0], rvalid[1]}, 0);
    chk("reset_owners", {wr_owner, rd_owner}, 0);
    do_reset();

    // s0 single-beat write, s1 untouched
    wr_txn(2'b01, 1, 1'b0, 0, 0);

    // Simultaneous reads after reset: s0 (4 beats) then the pending s1
    do_reset();
    rd_txn(2'b11, 4, 1'b0, 0);
    rd_txn(2'b10, 1, 1'b1, 0);

    // Arbitration order table
    do_reset();
    for (int i = 0; i < 8; i++) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
      wr_txn(vecs[i].req, vecs[i].nbeats, vecs[i].exp_fixed, 0, 0);
`else
      wr_txn(vecs[i].req, vecs[i].nbeats, vecs[i].exp_rr, 0, 0);
`endif
    end
    clear_inputs();

    // Concurrent s1 write and s0 read
    fork
      wr_txn(2'b10, 2, 1'b1, 0, 0);
      rd_txn(2'b01, 3, 1'b0, 0);
    join
    clear_inputs();

    // Backpressure: toggling wready, 5-cycle bready/rready stalls
    wr_txn(2'b01, 4, 1'b0, 1, 5);
    clear_inputs();
    rd_txn(2'b10, 3, 1'b1, 5);
    clear_inputs();

    // Reset during write beat 2 of 8
    awvalid[0] = 1; awaddr[0] = base(0); awid[0] = idof(0); awlen[0] = 8'd7;
    wvalid[0] = 1; wdata[0] = pat(0, 0); wlast[0] = 0;
    m_axi_awready = 1; m_axi_wready = 1;
    arvalid[1] = 1; m_axi_arready = 1;
    tick(); tick();
    awvalid[0] = 0;
    tick();
    wdata[0] = pat(0, 1);
    #1;
    chk("rst_pre_wvalid", m_axi_wvalid, 1);
    resetn = 0;
    #1;
    chk("rst_mid_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
        m_axi_rready, awready[0], wready[0], bvalid[0], arready[1], rvalid[1]}, 0);
    chk("rst_mid_owners", {wr_owner, rd_owner}, 0);
    clear_inputs();
    tick();
    resetn = 1;
    wr_txn(2'b11, 1, 1'b0, 0, 0);
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_axi4_mmio_arbiter
`default_nettype wire
